reg_pipe: RTL and testbench

REG_PIPE -- requirements
Module: reg_pipe

---
 rtl/reg_pipe_pkg.sv | 12 +
 rtl/reg_pipe_stage.sv | 46 ++++
 rtl/reg_pipe.sv | 91 +++++++++
 tb/tb_reg_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pipe_pkg.sv
// Shared defaults and helpers for the reg_pipe register pipeline.
package reg_pipe_pkg;

   localparam int REG_PIPE_WIDTH = 32;
   localparam int REG_PIPE_DEPTH = 4;

   // Bits needed to hold an occupancy value in 0..depth.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: a valid bit plus a data word.
// Reset zeroes both fields. Clear drops the valid bit and keeps the data.
// A load copies the upstream valid bit. Data is taken only when that bit is
// set, so a bubble does not disturb the word already held.
module pipe_stage
   import reg_pipe_pkg::*;
#(
   parameter int WIDTH = REG_PIPE_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic             in_v,
   input  logic [WIDTH-1:0] in_d,
   output logic             v_q,
   output logic [WIDTH-1:0] d_q
);

   logic             v_d;
   logic [WIDTH-1:0] d_d;

   // Next-state selection: clear wins over load, otherwise hold.
   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (clear) begin
         v_d = 1'b0;
      end else if (load) begin
         v_d = in_v;
         if (in_v) d_d = in_d;
      end
   end

   // Stage registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         v_q <= 1'b0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: a DEPTH-stage valid/ready register pipeline that collapses
// bubbles.
// Defining REG_PIPE_COUNT_EN adds the occupancy counter and the count port.
module reg_pipe
   import reg_pipe_pkg::*;
#(
   parameter int WIDTH = REG_PIPE_WIDTH,
   parameter int DEPTH = REG_PIPE_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
`ifdef REG_PIPE_COUNT_EN
   ,
   output logic [cnt_w(DEPTH)-1:0] count
`endif
);

   logic [DEPTH-1:0]            v;
   logic [DEPTH-1:0]            rdy;
   logic [DEPTH-1:0][WIDTH-1:0] d;

   // Stage i may load when some stage at or beyond i is empty, or when the
   // output drains this cycle. This is the ready chain written out flat, so
   // there is no bit-to-bit combinational path inside one vector.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             in_v;
      logic [WIDTH-1:0] in_d;

      if (i == 0) begin : g_head
         assign in_v = in_valid;
         assign in_d = in_data;
      end else begin : g_body
         assign in_v = v[i-1];
         assign in_d = d[i-1];
      end

      assign rdy[i] = out_ready || !(&v[DEPTH-1:i]);

      pipe_stage #(.WIDTH(WIDTH)) u_stage (
         .clk   (clk),
         .reset (reset),
         .load  (en && rdy[i]),
         .clear (flush),
         .in_v  (in_v),
         .in_d  (in_d),
         .v_q   (v[i]),
         .d_q   (d[i])
      );
   end

   assign in_ready  = en && !flush && rdy[0];
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

`ifdef REG_PIPE_COUNT_EN
   localparam int CW = cnt_w(DEPTH);

   logic          in_xfer;
   logic          out_xfer;
   logic [CW-1:0] count_d;
   logic [CW-1:0] count_q;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready && en && !flush;

   // Occupancy tracking: +1 on input only, -1 on output only, 0 on flush.
   always_comb begin
      count_d = count_q;
      if (flush)                     count_d = '0;
      else if (in_xfer && !out_xfer) count_d = count_q + CW'(1);
      else if (out_xfer && !in_xfer) count_d = count_q - CW'(1);
   end

   // Occupancy register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe (DEPTH=4, WIDTH=32).
// Contents are modelled as a queue of words tagged with their position.
module tb_reg_pipe;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset, en, flush, in_valid, out_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_ready, out_valid;
   logic [WIDTH-1:0] out_data;
`ifdef REG_PIPE_COUNT_EN
   logic [$clog2(DEPTH+1)-1:0] count;
`endif

   reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef REG_PIPE_COUNT_EN
      ,
      .count     (count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] d;
      int               pos;
   } item_t;

   item_t q[$];
   int    ncomp = 0;
   int    nfail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic r, input logic e, input logic f, input logic iv,
                      input logic [WIDTH-1:0] dat, input logic ordy);
      reset = r; en = e; flush = f; in_valid = iv; in_data = dat; out_ready = ordy;
   endtask

   task automatic chk_count(input string tag, input int exp);
`ifdef REG_PIPE_COUNT_EN
      chk(tag, 64'(count), 64'(exp));
`endif
   endtask

   // Compare against the model, then advance one clock and update the model.
   task automatic cyc();
      logic m_ir, m_ov;
      m_ir = en && !flush && (q.size() < DEPTH || out_ready);
      m_ov = (q.size() > 0) && (q[0].pos == DEPTH - 1);
      chk("m_in_ready", 64'(in_ready), 64'(m_ir));
      chk("m_out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) chk("m_out_data", 64'(out_data), 64'(q[0].d));
      chk_count("m_count", q.size());
      @(posedge clk);
      if (reset || flush) begin
         q.delete();
      end else if (en) begin
         if (out_ready) begin
            if (m_ov) void'(q.pop_front());
            foreach (q[k]) q[k].pos++;
         end else begin
            // Word k has k older words ahead of it. It moves only if a hole
            // remains beyond its current position.
            foreach (q[k]) if (q[k].pos < DEPTH - 1 - k) q[k].pos++;
         end
         if (m_ir && in_valid) q.push_back('{d: in_data, pos: 0});
      end
      #1;
   endtask

   initial begin
      int w, e;
      // Reset state
      drv(1, 0, 0, 0, '0, 0);
      @(posedge clk); #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk_count("rst_count", 0);
      cyc();

      // Single word: latency of exactly DEPTH cycles
      for (int k = 0; k < 7; k++) begin
         drv(0, 1, 0, k == 0, 32'hA5, 1);
         #1;
         chk("s1_out_valid", 64'(out_valid), 64'(k == 4));
         if (k == 4) chk("s1_out_data", 64'(out_data), 64'hA5);
         cyc();
      end

      // Back-to-back words 1..8 at full throughput
      for (int k = 0; k < 12; k++) begin
         drv(0, 1, 0, k < 8, 32'(k + 1), 1);
         #1;
         if (k < 8) chk("s2_in_ready", 64'(in_ready), 64'd1);
         if (k >= 4) begin
            chk("s2_out_valid", 64'(out_valid), 64'd1);
            chk("s2_out_data", 64'(out_data), 64'(k - 3));
         end
         cyc();
      end

      // Backpressure: four words fill the pipe, then drain 1..6 in order
      w = 1;
      for (int k = 0; k < 6; k++) begin
         drv(0, 1, 0, 1, 32'(w), 0);
         #1;
         chk("s3_in_ready", 64'(in_ready), 64'(k < 4));
         if (in_ready) w++;
         cyc();
      end
      chk_count("s3_count_full", 4);
      e = 1;
      for (int k = 0; k < 20 && e <= 6; k++) begin
         drv(0, 1, 0, w <= 6, 32'(w), 1);
         #1;
         if (in_valid && in_ready) w++;
         if (out_valid) begin
            chk("s3_order", 64'(out_data), 64'(e));
            e++;
         end
         cyc();
      end
      chk("s3_drained", 64'(e), 64'd7);

      // Flush with three words held and an input word offered
      for (int k = 0; k < 3; k++) begin
         drv(0, 1, 0, 1, 32'h30 + 32'(k), 0);
         #1;
         cyc();
      end
      drv(0, 1, 1, 1, 32'h77, 0);
      #1;
      chk("s4_in_ready", 64'(in_ready), 64'd0);
      cyc();
      drv(0, 1, 0, 0, '0, 1);
      #1;
      chk("s4_out_valid", 64'(out_valid), 64'd0);
      chk_count("s4_count", 0);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("s4_no_word", 64'(out_valid), 64'd0);
         cyc();
      end

      // en=0 freeze with two words inside
      for (int k = 0; k < 4; k++) begin
         drv(0, 1, 0, k < 2, (k == 0) ? 32'h11 : 32'h22, 1);
         #1;
         cyc();
      end
      for (int k = 0; k < 5; k++) begin
         drv(0, 0, 0, 1, 32'h99, 1);
         #1;
         chk("s5_frz_valid", 64'(out_valid), 64'd1);
         chk("s5_frz_data", 64'(out_data), 64'h11);
         chk("s5_frz_ready", 64'(in_ready), 64'd0);
         cyc();
      end
      drv(0, 1, 0, 0, '0, 1);
      #1;
      chk("s5_first", 64'(out_data), 64'h11);
      cyc();
      chk("s5_second_v", 64'(out_valid), 64'd1);
      chk("s5_second", 64'(out_data), 64'h22);
      cyc();
      chk("s5_empty", 64'(out_valid), 64'd0);
      cyc();

      // Reset mid-stream with a full pipe
      for (int k = 0; k < 4; k++) begin
         drv(0, 1, 0, 1, 32'hC0 + 32'(k), 0);
         #1;
         cyc();
      end
      chk_count("s6_count_full", 4);
      drv(1, 1, 0, 0, '0, 0);
      #1;
      cyc();
      chk("s6_out_valid", 64'(out_valid), 64'd0);
      chk("s6_out_data", 64'(out_data), 64'd0);
      chk_count("s6_count", 0);
      for (int k = 0; k < 6; k++) begin
         drv(0, 1, 0, k == 0, 32'h5A, 1);
         #1;
         chk("s6_latency", 64'(out_valid), 64'(k == 4));
         cyc();
      end

      // Randomised traffic against the model
      for (int k = 0; k < 800; k++) begin
         drv(($urandom % 97) == 0, ($urandom % 8) != 0, ($urandom % 29) == 0,
             ($urandom % 3) != 0, $urandom, ($urandom % 4) != 0);
         #1;
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
